// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// load/store path, with a tag pipeline that routes fixed-latency read data home.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  // Handshake: a requester holds req and payload stable until it sees gnt in
  // the same cycle; a transfer happens on any cycle where gnt is high. The
  // response side (rvalid) is never back-pressured.

  logic                   last_d_q, last_d_d;
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LATENCY-1:0] tag_src_q, tag_src_d;
  logic                   any_req;
  logic                   sel_d;
  logic                   accept;

  always_comb begin
    any_req     = (if_req_i | d_req_i) & ~rst_i;
    // On a tie the port that did not win last gets the memory.
    sel_d       = d_req_i & (~if_req_i | ~last_d_q);
    accept      = any_req & mem_gnt_i;

    mem_req_o   = any_req;
    mem_addr_o  = if_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = {BE_W{1'b1}};
    mem_wdata_o = '0;
    if (sel_d) begin
      mem_addr_o  = d_addr_i;
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_wdata_o = d_wdata_i;
    end

    if_gnt_o = accept & ~sel_d;
    d_gnt_o  = accept & sel_d;
  end

  always_comb begin
    last_d_d     = accept ? sel_d : last_d_q;
    tag_vld_d    = '0;
    tag_src_d    = '0;
    tag_vld_d[0] = accept;
    tag_src_d[0] = sel_d;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_src_d[i] = tag_src_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_d_q  <= 1'b1;
      tag_vld_q <= '0;
      tag_src_q <= '0;
    end else begin
      last_d_q  <= last_d_d;
      tag_vld_q <= tag_vld_d;
      tag_src_q <= tag_src_d;
    end
  end

  // The oldest tag lines up with the word the memory is returning now.
  always_comb begin
    if_rvalid_o = tag_vld_q[MEM_LATENCY-1] & ~tag_src_q[MEM_LATENCY-1];
    d_rvalid_o  = tag_vld_q[MEM_LATENCY-1] &  tag_src_q[MEM_LATENCY-1];
    if_rdata_o  = mem_rdata_i;
    d_rdata_o   = mem_rdata_i;
  end

endmodule
